// File: rtl/sa_pkg.sv
// sa_pkg: shared types, default widths and saturation limits for the systolic-array PE
package sa_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 19;
    localparam int SAT_W      = 64;

    typedef enum logic {EMPTY, PEND} res_state_t;

    // Limits are returned SAT_W wide; callers cast down to their accumulator width.
    function automatic logic [SAT_W-1:0] sat_max(input int w, input bit sgn);
        return sgn ? (SAT_W'(1) << (w - 1)) - SAT_W'(1) : (SAT_W'(1) << w) - SAT_W'(1);
    endfunction

    function automatic logic [SAT_W-1:0] sat_min(input int w, input bit sgn);
        return sgn ? SAT_W'(1) << (w - 1) : '0;
    endfunction

endpackage

// File: rtl/sa_mac_sat.sv
// sa_mac_sat: combinational multiply-accumulate with overflow detect and optional clamp
module sa_mac_sat
    import sa_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc_nxt,
    output logic              ovf
);

    localparam int PW = 2 * DATA_W;
    localparam bit SG = SIGNED != 0;
    localparam bit SAT = SATURATE != 0;
    localparam logic [ACC_W-1:0] MAXV = ACC_W'(sat_max(ACC_W, SG));
    localparam logic [ACC_W-1:0] MINV = ACC_W'(sat_min(ACC_W, SG));

    logic [PW-1:0]    prod_u, prod_s, prod;
    logic [ACC_W:0]   ext_p, ext_acc, sum;

    // One bit of headroom above ACC_W holds the true sum of any acc + product.
    always_comb begin
        prod_u  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        prod_s  = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        prod    = SG ? prod_s : prod_u;
        ext_p   = {{(ACC_W + 1 - PW){SG & prod[PW-1]}}, prod};
        ext_acc = {SG & acc[ACC_W-1], acc};
        sum     = ext_acc + ext_p;
        ovf     = SG ? sum[ACC_W] ^ sum[ACC_W-1] : sum[ACC_W];
        acc_nxt = (ovf && SAT) ? ((SG && sum[ACC_W]) ? MINV : MAXV) : sum[ACC_W-1:0];
    end

endmodule

// File: rtl/sa_pe_os.sv
// sa_pe_os: output-stationary systolic PE with tagged operands, double-buffered
// result and a one-register-per-PE vertical drain chain
module sa_pe_os
    import sa_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [DATA_W-1:0] A_in,
    input  logic              A_vld_in,
    input  logic              A_last_in,
    input  logic [DATA_W-1:0] B_in,
    input  logic              B_vld_in,
    output logic [DATA_W-1:0] A_out,
    output logic              A_vld_out,
    output logic              A_last_out,
    output logic [DATA_W-1:0] B_out,
    output logic              B_vld_out,
    input  logic [ACC_W-1:0]  DRAIN_in,
    input  logic              DRAIN_vld_in,
    output logic [ACC_W-1:0]  DRAIN_out,
    output logic              DRAIN_vld_out,
    output logic              OVF,
    output logic              ERR
);

    logic [DATA_W-1:0] a_q, b_q;
    logic              a_vld_q, a_last_q, b_vld_q;
    logic [ACC_W-1:0]  acc, res, acc_nxt, drain_q;
    logic              drain_vld_q, ovf_q, err_q, mac_ovf;
    logic              pair, one_side, close, emit, lost;
    res_state_t        state, state_nxt;

    sa_mac_sat #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .SIGNED  (SIGNED),
        .SATURATE(SATURATE)
    ) u_mac (
        .acc    (acc),
        .a      (a_q),
        .b      (b_q),
        .acc_nxt(acc_nxt),
        .ovf    (mac_ovf)
    );

    // Upstream drain traffic always wins the slot; a pending result waits.
    always_comb begin
        pair      = a_vld_q & b_vld_q;
        one_side  = a_vld_q ^ b_vld_q;
        close     = pair & a_last_q;
        emit      = (state == PEND) & ~DRAIN_vld_in;
        lost      = close & (state == PEND) & ~emit;
        state_nxt = close ? PEND : emit ? EMPTY : state;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= EMPTY;
        end else if (EN) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q         <= '0;
            b_q         <= '0;
            a_vld_q     <= 1'b0;
            a_last_q    <= 1'b0;
            b_vld_q     <= 1'b0;
            acc         <= '0;
            res         <= '0;
            drain_q     <= '0;
            drain_vld_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else if (EN) begin
            a_q         <= A_in;
            b_q         <= B_in;
            a_vld_q     <= A_vld_in;
            a_last_q    <= A_last_in;
            b_vld_q     <= B_vld_in;
            acc         <= close ? '0 : pair ? acc_nxt : acc;
            res         <= close ? acc_nxt : res;
            drain_q     <= DRAIN_vld_in ? DRAIN_in : emit ? res : drain_q;
            drain_vld_q <= DRAIN_vld_in | emit;
            ovf_q       <= ovf_q | (pair & mac_ovf);
            err_q       <= err_q | one_side | lost;
        end
    end

    assign A_out         = a_q;
    assign A_vld_out     = a_vld_q;
    assign A_last_out    = a_last_q;
    assign B_out         = b_q;
    assign B_vld_out     = b_vld_q;
    assign DRAIN_out     = drain_q;
    assign DRAIN_vld_out = drain_vld_q;
    assign OVF           = ovf_q;
    assign ERR           = err_q;

endmodule

// File: tb/tb_sa_pe_os.sv
// tb_sa_pe_os: directed checks of sa_pe_os; one unsigned default instance plus
// signed saturating and signed wrapping 16-bit instances sharing the same stimulus
module tb_sa_pe_os;

    logic        CLK, RST, EN;
    logic [7:0]  A_in, B_in;
    logic        A_vld_in, A_last_in, B_vld_in;
    logic [18:0] DRAIN_in;
    logic        DRAIN_vld_in;

    logic [7:0]  a_out, b_out, s_a_out, s_b_out, w_a_out, w_b_out;
    logic        a_vld_out, a_last_out, b_vld_out;
    logic        s_a_vld_out, s_a_last_out, s_b_vld_out;
    logic        w_a_vld_out, w_a_last_out, w_b_vld_out;
    logic [18:0] d_out;
    logic [15:0] s_d_out, w_d_out;
    logic        d_vld, s_d_vld, w_d_vld, ovf, s_ovf, w_ovf, err, s_err, w_err;

    int n_chk = 0;
    int n_fail = 0;

    sa_pe_os dut (
        .CLK(CLK), .RST(RST), .EN(EN),
        .A_in(A_in), .A_vld_in(A_vld_in), .A_last_in(A_last_in),
        .B_in(B_in), .B_vld_in(B_vld_in),
        .A_out(a_out), .A_vld_out(a_vld_out), .A_last_out(a_last_out),
        .B_out(b_out), .B_vld_out(b_vld_out),
        .DRAIN_in(DRAIN_in), .DRAIN_vld_in(DRAIN_vld_in),
        .DRAIN_out(d_out), .DRAIN_vld_out(d_vld),
        .OVF(ovf), .ERR(err)
    );

    sa_pe_os #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1)) dut_sat (
        .CLK(CLK), .RST(RST), .EN(EN),
        .A_in(A_in), .A_vld_in(A_vld_in), .A_last_in(A_last_in),
        .B_in(B_in), .B_vld_in(B_vld_in),
        .A_out(s_a_out), .A_vld_out(s_a_vld_out), .A_last_out(s_a_last_out),
        .B_out(s_b_out), .B_vld_out(s_b_vld_out),
        .DRAIN_in(DRAIN_in[15:0]), .DRAIN_vld_in(DRAIN_vld_in),
        .DRAIN_out(s_d_out), .DRAIN_vld_out(s_d_vld),
        .OVF(s_ovf), .ERR(s_err)
    );

    sa_pe_os #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0)) dut_wrap (
        .CLK(CLK), .RST(RST), .EN(EN),
        .A_in(A_in), .A_vld_in(A_vld_in), .A_last_in(A_last_in),
        .B_in(B_in), .B_vld_in(B_vld_in),
        .A_out(w_a_out), .A_vld_out(w_a_vld_out), .A_last_out(w_a_last_out),
        .B_out(w_b_out), .B_vld_out(w_b_vld_out),
        .DRAIN_in(DRAIN_in[15:0]), .DRAIN_vld_in(DRAIN_vld_in),
        .DRAIN_out(w_d_out), .DRAIN_vld_out(w_d_vld),
        .OVF(w_ovf), .ERR(w_err)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic av, input logic bv, input logic last);
        A_in = a;
        B_in = b;
        A_vld_in = av;
        B_vld_in = bv;
        A_last_in = last;
    endtask

    task automatic do_reset;
        drive(0, 0, 0, 0, 0);
        DRAIN_in = 0;
        DRAIN_vld_in = 0;
        EN = 1;
        RST = 1;
        tick;
        tick;
        RST = 0;
    endtask

    task automatic test_reset;
        do_reset;
        n_chk++;
        if ({a_out, a_vld_out, a_last_out, b_out, b_vld_out, d_out, d_vld, ovf, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {a_out, a_vld_out, a_last_out, b_out, b_vld_out, d_out, d_vld, ovf, err});
        end
    endtask

    task automatic test_unsigned_tile;
        do_reset;
        drive(3, 4, 1, 1, 0); tick;
        drive(5, 6, 1, 1, 0); tick;
        drive(7, 8, 1, 1, 1); tick;
        n_chk++;
        if ({a_out, b_out, a_vld_out, b_vld_out, a_last_out} !== {8'd7, 8'd8, 3'b111}) begin
            n_fail++;
            $display("FAIL passthrough: got %h required %h", {a_out, b_out, a_vld_out, b_vld_out, a_last_out}, {8'd7, 8'd8, 3'b111});
        end
        drive(0, 0, 0, 0, 0); tick;
        n_chk++;
        if (d_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_early: DRAIN_vld_out=%b required 0", d_vld);
        end
        tick;
        n_chk++;
        if (d_vld !== 1'b1 || d_out !== 19'd98) begin
            n_fail++;
            $display("FAIL unsigned_result: got vld=%b data=%0d required vld=1 data=98", d_vld, d_out);
        end
        tick;
        n_chk++;
        if (d_vld !== 1'b0 || d_out !== 19'd98) begin
            n_fail++;
            $display("FAIL drain_idle_hold: got vld=%b data=%0d required vld=0 data=98", d_vld, d_out);
        end
        drive(2, 3, 1, 1, 1); tick;
        drive(0, 0, 0, 0, 0); tick; tick;
        n_chk++;
        if (d_vld !== 1'b1 || d_out !== 19'd6 || ovf !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL acc_cleared: got vld=%b data=%0d ovf=%b err=%b required 1 6 0 0", d_vld, d_out, ovf, err);
        end
    endtask

    task automatic test_signed_sat;
        do_reset;
        drive(8'h80, 8'h80, 1, 1, 0); tick;
        drive(8'h80, 8'h80, 1, 1, 1); tick;
        drive(0, 0, 0, 0, 0); tick;
        n_chk++;
        if (s_ovf !== 1'b1 || w_ovf !== 1'b1 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_flags: got sat=%b wrap=%b unsigned=%b required 1 1 0", s_ovf, w_ovf, ovf);
        end
        tick;
        n_chk++;
        if (s_d_vld !== 1'b1 || s_d_out !== 16'h7FFF) begin
            n_fail++;
            $display("FAIL signed_clamp: got vld=%b data=%h required vld=1 data=7fff", s_d_vld, s_d_out);
        end
        n_chk++;
        if (w_d_vld !== 1'b1 || w_d_out !== 16'h8000) begin
            n_fail++;
            $display("FAIL signed_wrap: got vld=%b data=%h required vld=1 data=8000", w_d_vld, w_d_out);
        end
        n_chk++;
        if (d_vld !== 1'b1 || d_out !== 19'd32768) begin
            n_fail++;
            $display("FAIL unsigned_wide: got vld=%b data=%0d required vld=1 data=32768", d_vld, d_out);
        end
    endtask

    task automatic test_drain_contention;
        logic [18:0] exp [4];
        exp[0] = 19'd100; exp[1] = 19'd200; exp[2] = 19'd300; exp[3] = 19'd10;
        do_reset;
        drive(2, 5, 1, 1, 1); tick;
        drive(0, 0, 0, 0, 0); tick;
        for (int i = 0; i < 4; i++) begin
            DRAIN_vld_in = i < 3;
            DRAIN_in = i < 3 ? exp[i] : 19'd0;
            tick;
            n_chk++;
            if (d_vld !== 1'b1 || d_out !== exp[i]) begin
                n_fail++;
                $display("FAIL contention_%0d: got vld=%b data=%0d required vld=1 data=%0d", i, d_vld, d_out, exp[i]);
            end
        end
        tick;
        n_chk++;
        if (d_vld !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_done: got vld=%b err=%b required 0 0", d_vld, err);
        end
    endtask

    task automatic test_overwrite;
        do_reset;
        drive(2, 3, 1, 1, 1); tick;
        drive(4, 5, 1, 1, 1); DRAIN_vld_in = 1; DRAIN_in = 7; tick;
        n_chk++;
        if (err !== 1'b0 || d_out !== 19'd7) begin
            n_fail++;
            $display("FAIL overwrite_first: got err=%b data=%0d required 0 7", err, d_out);
        end
        drive(0, 0, 0, 0, 0); DRAIN_in = 8; tick;
        n_chk++;
        if (err !== 1'b1 || d_vld !== 1'b1 || d_out !== 19'd8) begin
            n_fail++;
            $display("FAIL overwrite_err: got err=%b vld=%b data=%0d required 1 1 8", err, d_vld, d_out);
        end
        DRAIN_vld_in = 0; DRAIN_in = 0; tick;
        n_chk++;
        if (d_vld !== 1'b1 || d_out !== 19'd20) begin
            n_fail++;
            $display("FAIL overwrite_emit: got vld=%b data=%0d required vld=1 data=20", d_vld, d_out);
        end
        tick;
        n_chk++;
        if (d_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL overwrite_single: DRAIN_vld_out=%b required 0", d_vld);
        end
    endtask

    task automatic test_one_sided;
        do_reset;
        drive(9, 0, 1, 0, 0); tick;
        n_chk++;
        if (a_vld_out !== 1'b1 || b_vld_out !== 1'b0 || a_out !== 8'd9 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL one_sided_pass: got avld=%b bvld=%b a=%0d err=%b required 1 0 9 0", a_vld_out, b_vld_out, a_out, err);
        end
        drive(1, 1, 1, 1, 1); tick;
        n_chk++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL one_sided_err: ERR=%b required 1", err);
        end
        drive(0, 0, 0, 0, 0); tick; tick;
        n_chk++;
        if (d_vld !== 1'b1 || d_out !== 19'd1) begin
            n_fail++;
            $display("FAIL one_sided_acc: got vld=%b data=%0d required vld=1 data=1", d_vld, d_out);
        end
    endtask

    task automatic test_stall_reset;
        do_reset;
        drive(3, 3, 1, 1, 0); tick;
        drive(4, 4, 1, 1, 1); EN = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_chk++;
            if ({a_out, b_out, a_vld_out, a_last_out, d_vld, err} !== {8'd3, 8'd3, 4'b1000}) begin
                n_fail++;
                $display("FAIL stall_%0d: got %h required %h", i, {a_out, b_out, a_vld_out, a_last_out, d_vld, err}, {8'd3, 8'd3, 4'b1000});
            end
        end
        EN = 1; RST = 1; tick;
        RST = 0; drive(0, 0, 0, 0, 0);
        n_chk++;
        if ({a_out, a_vld_out, a_last_out, b_out, b_vld_out, d_out, d_vld, ovf, err} !== '0) begin
            n_fail++;
            $display("FAIL midtile_reset: got %h required 0", {a_out, a_vld_out, a_last_out, b_out, b_vld_out, d_out, d_vld, ovf, err});
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            n_chk++;
            if (d_vld !== 1'b0 || d_out !== 19'd0) begin
                n_fail++;
                $display("FAIL no_emit_%0d: got vld=%b data=%0d required 0 0", i, d_vld, d_out);
            end
        end
    endtask

    initial begin
        test_reset;
        test_unsigned_tile;
        test_signed_sat;
        test_drain_contention;
        test_overwrite;
        test_one_sided;
        test_stall_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
